// File: rtl/stochastic_pkg.sv
// Shared definitions for the stochastic N-channel scaled adder: LFSR shape,
// FSM state encoding and per-instance seed derivation.
package stochastic_pkg;

  localparam int LFSR_W = 31;
  // Fibonacci taps for x^31 + x^28 + 1 (bit indices of the shift register)
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  // Seed for LFSR instance k; a zero seed would lock the LFSR, so map it to 1.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] base,
                                                  input int unsigned k);
    logic [LFSR_W-1:0] kk;
    logic [LFSR_W-1:0] s;
    kk = LFSR_W'(k);
    s  = base ^ (kk * 31'h2545F491);
    if (s == '0) s = 31'd1;
    return s;
  endfunction

endpackage

// File: rtl/sn_lfsr_cmp.sv
// One free-running 31-bit Fibonacci LFSR plus a registered comparator that
// turns a probability into a stochastic bitstream. The low RND_W LFSR bits are
// exported so the same block can serve as a plain random source.
module sn_lfsr_cmp
  import stochastic_pkg::*;
#(
  parameter int                WIDTH = 9,
  parameter logic [LFSR_W-1:0] SEED  = 31'd1,
  parameter int                RND_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] prob,
  output logic             sn,
  output logic [RND_W-1:0] rnd
);

  logic [LFSR_W-1:0] lfsr;
  logic              sn_p1;

  // LFSR advances every cycle outside reset so streams stay decorrelated across runs
  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[LFSR_W-2:0], lfsr[TAP_HI] ^ lfsr[TAP_LO]};
  end

  // stage 1: unsigned compare, bit is 1 with probability prob/2^WIDTH
  always_ff @(posedge clk) begin
    sn_p1 <= (lfsr[WIDTH-1:0] < prob);
  end

  assign sn  = sn_p1;
  assign rnd = lfsr[RND_W-1:0];

endmodule

// File: rtl/stochastic_mux_adder_n.sv
// N-channel stochastic scaled adder: each latched probability drives its own
// comparator stream, a random select picks one stream per cycle, and a counter
// integrates 2^WIN_LOG2 selected bits to give (sum P_k)/N_CH.
module stochastic_mux_adder_n
  import stochastic_pkg::*;
#(
  parameter int                N_CH      = 4,
  parameter int                WIDTH     = 9,
  parameter int                WIN_LOG2  = 17,
  parameter logic [LFSR_W-1:0] SEED_BASE = 31'd134223335
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cont_mode,
  input  logic [N_CH*WIDTH-1:0] prob_in,
  output logic                  busy,
  output logic [WIDTH-1:0]      result,
  output logic                  result_valid,
  output logic                  sat
);

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam int SHIFT = WIN_LOG2 - WIDTH;

  state_t                state, state_nx;
  logic [WIN_LOG2-1:0]   tmr;
  logic [N_CH*WIDTH-1:0] prob_q;
  logic [N_CH-1:0]       sn_p1;
  logic [N_CH-1:0]       ch_rnd_unused;
  logic                  out_bit_p2;
  logic [CNT_W-1:0]      count;
  logic                  enter_prime;

  // Scale the window count to WIDTH bits; the count never exceeds 2^WIN_LOG2,
  // so the top bit of the shifted value is set only at exactly 2^WIDTH.
  function automatic logic [WIDTH:0] scale_sat(input logic [CNT_W-1:0] c);
    logic [WIDTH:0] sh;
    sh = (WIDTH+1)'(c >> SHIFT);
    if (sh[WIDTH]) return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, sh[WIDTH-1:0]};
  endfunction

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    sn_lfsr_cmp #(
      .WIDTH(WIDTH),
      .SEED (lfsr_seed(SEED_BASE, k)),
      .RND_W(1)
    ) u_ch (
      .clk (clk),
      .rst (rst_n),
      .prob(prob_q[k*WIDTH +: WIDTH]),
      .sn  (sn_p1[k]),
      .rnd (ch_rnd_unused[k])
    );
  end

  if (N_CH > 1) begin : g_sel
    localparam int SEL_W = $clog2(N_CH);
    logic [SEL_W-1:0] sel_rnd;
    logic [SEL_W-1:0] sel_q_p1;
    logic             sel_sn_unused;

    sn_lfsr_cmp #(
      .WIDTH(WIDTH),
      .SEED (lfsr_seed(SEED_BASE, N_CH)),
      .RND_W(SEL_W)
    ) u_sel (
      .clk (clk),
      .rst (rst_n),
      .prob('0),
      .sn  (sel_sn_unused),
      .rnd (sel_rnd)
    );

    // stage 1: register the select alongside the comparator outputs
    always_ff @(posedge clk) begin
      sel_q_p1 <= sel_rnd;
    end

    // stage 2: mux one channel stream
    always_ff @(posedge clk) begin
      out_bit_p2 <= sn_p1[sel_q_p1];
    end
  end else begin : g_one
    // stage 2: single channel, select is constant
    always_ff @(posedge clk) begin
      out_bit_p2 <= sn_p1[0];
    end
  end

  // FSM state and phase timer; timer restarts on every state change
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nx;
      tmr   <= (state_nx != state) ? '0 : tmr + 1'b1;
    end
  end

  // Next state: PRIME fills the two-stage pipeline, RUN spans the full window
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PRIME;
      PRIME:   if (tmr[0]) state_nx = RUN;
      RUN:     if (&tmr) state_nx = DONE;
      DONE:    state_nx = cont_mode ? PRIME : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_prime = (state != PRIME) && (state_nx == PRIME);
  assign busy        = (state != IDLE);

  // Latch probabilities only on a fresh start; continuous reruns reuse them
  always_ff @(posedge clk) begin
    if (rst_n)                       prob_q <= '0;
    else if (state == IDLE && start) prob_q <= prob_in;
  end

  // Window integrator, cleared on every entry into PRIME
  always_ff @(posedge clk) begin
    if (rst_n)            count <= '0;
    else if (enter_prime) count <= '0;
    else if (state == RUN) count <= count + CNT_W'(out_bit_p2);
  end

  // Publish the scaled result when leaving DONE; valid is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst_n) begin
      result       <= '0;
      sat          <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state == DONE);
      if (state == DONE) {sat, result} <= scale_sat(count);
    end
  end

endmodule

// File: tb/tb_stochastic_mux_adder_n.sv
// Directed bench for stochastic_mux_adder_n: N_CH=2 main instance plus
// N_CH=4 and N_CH=1 builds, all with WIDTH=9, WIN_LOG2=12.
module tb_stochastic_mux_adder_n;

  localparam int LAT = 4099;

  logic        clk = 1'b0;
  logic        rst;
  logic        cont;
  logic        cont_off;
  logic        start2, start4, start1;
  logic [17:0] prob2;
  logic [35:0] prob4;
  logic [8:0]  prob1;
  logic        busy2, busy4, busy1;
  logic [8:0]  res2, res4, res1;
  logic        rv2, rv4, rv1;
  logic        sat2, sat4, sat1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int p0;
    int p1;
    int lo;
    int hi;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  stochastic_mux_adder_n #(.N_CH(2), .WIDTH(9), .WIN_LOG2(12)) dut2 (
    .clk(clk), .rst_n(rst), .start(start2), .cont_mode(cont), .prob_in(prob2),
    .busy(busy2), .result(res2), .result_valid(rv2), .sat(sat2));

  stochastic_mux_adder_n #(.N_CH(4), .WIDTH(9), .WIN_LOG2(12)) dut4 (
    .clk(clk), .rst_n(rst), .start(start4), .cont_mode(cont_off), .prob_in(prob4),
    .busy(busy4), .result(res4), .result_valid(rv4), .sat(sat4));

  stochastic_mux_adder_n #(.N_CH(1), .WIDTH(9), .WIN_LOG2(12)) dut1 (
    .clk(clk), .rst_n(rst), .start(start1), .cont_mode(cont_off), .prob_in(prob1),
    .busy(busy1), .result(res1), .result_valid(rv1), .sat(sat1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Pulse start on one instance (0: N_CH=2, 1: N_CH=4, 2: N_CH=1) and wait for
  // its result; lat counts edges from the start edge, -1 on timeout.
  task automatic run_one(input int which, output int lat, output int res,
                         output int s, output int b);
    lat = -1; res = -1; s = -1; b = -1;
    case (which)
      0: start2 = 1'b1;
      1: start4 = 1'b1;
      default: start1 = 1'b1;
    endcase
    tick();
    start2 = 1'b0; start4 = 1'b0; start1 = 1'b0;
    for (int n = 1; n <= 5000; n++) begin
      tick();
      if (which == 0 && rv2) begin lat = n; res = int'(res2); s = int'(sat2); b = int'(busy2); break; end
      if (which == 1 && rv4) begin lat = n; res = int'(res4); s = int'(sat4); b = int'(busy4); break; end
      if (which == 2 && rv1) begin lat = n; res = int'(res1); s = int'(sat1); b = int'(busy1); break; end
    end
  endtask

  initial begin
    int lat, res, s, b, nval, first, prev;

    vecs[0] = '{p0: 0,   p1: 0,   lo: 0,   hi: 0};
    vecs[1] = '{p0: 256, p1: 256, lo: 244, hi: 268};
    vecs[2] = '{p0: 256, p1: 0,   lo: 116, hi: 140};
    vecs[3] = '{p0: 511, p1: 511, lo: 500, hi: 511};

    rst = 1'b1; cont = 1'b0; cont_off = 1'b0;
    start2 = 1'b0; start4 = 1'b0; start1 = 1'b0;
    prob2 = '0; prob4 = '0; prob1 = '0;
    tick(); tick();
    chk("reset_busy", int'(busy2), 0);
    chk("reset_result", int'(res2), 0);
    chk("reset_valid", int'(rv2), 0);
    chk("reset_sat", int'(sat2), 0);
    rst = 1'b0;
    tick();

    // table-driven single runs
    for (int i = 0; i < 4; i++) begin
      prob2 = {9'(vecs[i].p1), 9'(vecs[i].p0)};
      run_one(0, lat, res, s, b);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
      chk_rng($sformatf("vec%0d_result", i), res, vecs[i].lo, vecs[i].hi);
      chk($sformatf("vec%0d_sat", i), s, 0);
      chk($sformatf("vec%0d_busy", i), b, 0);
      tick();
      chk($sformatf("vec%0d_pulse_len", i), int'(rv2), 0);
    end

    // start held high through the run: no restart, exactly one pulse
    prob2 = {9'd256, 9'd256};
    start2 = 1'b1;
    tick();
    nval = 0; first = -1;
    for (int n = 1; n <= 4200; n++) begin
      if (n == 4000) start2 = 1'b0;
      tick();
      if (rv2) begin
        nval++;
        if (first < 0) first = n;
      end
    end
    chk("held_start_pulses", nval, 1);
    chk("held_start_latency", first, LAT);
    chk("held_start_idle", int'(busy2), 0);

    // continuous mode: back-to-back windows, then drop cont_mode
    prob2 = {9'd128, 9'd384};
    cont = 1'b1;
    run_one(0, lat, res, s, b);
    chk("cont0_latency", lat, LAT);
    chk_rng("cont0_result", res, 244, 268);
    chk("cont0_busy", b, 1);
    for (int p = 1; p <= 2; p++) begin
      prev = -1;
      for (int n = 1; n <= 5000; n++) begin
        tick();
        if (rv2) begin prev = n; break; end
      end
      chk($sformatf("cont%0d_period", p), prev, LAT);
      chk_rng($sformatf("cont%0d_result", p), int'(res2), 244, 268);
      if (p == 1) cont = 1'b0;
    end
    chk("cont_end_idle", int'(busy2), 0);
    nval = 0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (rv2) nval++;
    end
    chk("cont_no_extra_pulse", nval, 0);

    // reset mid-run aborts with no stale pulse
    prob2 = {9'd256, 9'd256};
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 1; n <= 1000; n++) tick();
    chk("midrun_busy", int'(busy2), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(busy2), 0);
    chk("abort_result", int'(res2), 0);
    chk("abort_valid", int'(rv2), 0);
    chk("abort_sat", int'(sat2), 0);
    nval = 0;
    for (int n = 1; n <= 4200; n++) begin
      tick();
      if (rv2) nval++;
    end
    chk("abort_no_stale", nval, 0);
    prob2 = '0;
    run_one(0, lat, res, s, b);
    chk("fresh_latency", lat, LAT);
    chk("fresh_result", res, 0);
    chk("fresh_sat", s, 0);

    // other channel counts
    prob4 = {9'd0, 9'd0, 9'd0, 9'd511};
    run_one(1, lat, res, s, b);
    chk("n4_latency", lat, LAT);
    chk_rng("n4_result", res, 116, 140);
    chk("n4_sat", s, 0);

    prob1 = 9'd300;
    run_one(2, lat, res, s, b);
    chk("n1_latency", lat, LAT);
    chk_rng("n1_result", res, 288, 312);
    chk("n1_sat", s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stochastic_mux_adder_n.md
Name: stochastic_mux_adder_n

Overview:
Parametrised N-channel stochastic scaled adder, successor to the 2-input fixed-window adder. Each of N_CH latched WIDTH-bit probabilities is converted to a stochastic bitstream (LFSR comparator). A uniform random select picks one stream per cycle, and an up-counter integrates 2^WIN_LOG2 output bits. The result is (sum of P_k)/N_CH as a WIDTH-bit value, with start/valid handshake and optional continuous re-run.

Parameters:
N_CH, 4, channel count; power of 2, 1..16
WIDTH, 9, probability/result width; 4..16
WIN_LOG2, 17, log2 of integration window in samples; must be >= WIDTH
SEED_BASE, 31'd134223335, base LFSR seed; per-channel seeds derived in package

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; synchronous, active-high (reset when 1)
start  in  1  request; sampled only in IDLE
cont_mode  in  1  1 = auto-restart after each result using latched probabilities
prob_in  in  N_CH*WIDTH  channel k at [k*WIDTH +: WIDTH]; P_k = prob/2^WIDTH
busy  out  1  high in PRIME/RUN/DONE
result  out  WIDTH  last completed scaled sum; held until next completion
result_valid  out  1  one-cycle pulse when result updates
sat  out  1  set with result when count saturated (count == 2^WIN_LOG2); held with result

Behaviour:
- Reset (rst_n=1 at edge): state=IDLE; result=0, result_valid=0, sat=0, busy=0; count=0; every LFSR = its package seed; probability latches=0. Reset wins over all other inputs and aborts any run.
- FSM: IDLE -> PRIME on start=1; latch prob_in and clear count.
- PRIME lasts exactly 2 cycles to fill the comparator and mux pipeline; samples are not counted.
- RUN lasts exactly 2^WIN_LOG2 cycles; each cycle count += mux output bit.
- DONE lasts 1 cycle: result_valid=1, result/sat updated. Then go to PRIME if cont_mode=1 (latches unchanged, count cleared), else IDLE.
- start outside IDLE is ignored. cont_mode is sampled in DONE only; clearing it mid-run ends after the current window.
- Latency: if start is sampled at edge t, result_valid is high in the cycle after edge t+3+2^WIN_LOG2.
- LFSRs: N_CH channel LFSRs plus 1 select LFSR, each 31-bit Fibonacci x^31+x^28+1. Shift every cycle in all states except reset, so streams stay decorrelated across runs.
- Pipeline stage 1: sn_k <= (lfsr_k[WIDTH-1:0] < prob_q_k), unsigned compare; sel_q <= lfsr_sel[SEL_W-1:0], SEL_W=log2(N_CH). For N_CH=1, sel is constant 0.
- Pipeline stage 2: out_bit <= sn[sel_q].
- Count is WIN_LOG2+1 bits, so it never wraps.
- result = count >> (WIN_LOG2-WIDTH). If that value equals 2^WIDTH, result=2^WIDTH-1 and sat=1; otherwise sat=0.
- prob=0 on every channel gives count=0 exactly. prob is never compared >= 2^WIDTH, so P=1 is not representable (max (2^WIDTH-1)/2^WIDTH).

Decomposition:
- Package stochastic_pkg: LFSR_W=31, tap positions, state enum {IDLE, PRIME, RUN, DONE}, and function lfsr_seed(k) = SEED_BASE ^ (k*31'h2545F491), forced to 31'd1 if the result is 0.
- Sub-module sn_lfsr_cmp (params WIDTH, SEED): one LFSR plus registered comparator. Instantiate N_CH times via generate; the select LFSR reuses it with its compare output unused.
- FSM, mux and counter stay in the top module.

Test Plan:
- Sim params N_CH=2, WIDTH=9, WIN_LOG2=12. All probs 0, start pulse -> result_valid exactly 4099 cycles after the start edge; result=0, sat=0, busy low afterwards.
- prob={256,256} -> result 256 +/-12; prob={256,0} -> result 128 +/-12; prob={511,511} -> result >= 500, sat=0.
- start held high during RUN; second start 100 cycles in -> no restart; exactly one result_valid at the nominal cycle.
- cont_mode=1, prob={384,128} -> result_valid pulses every 4099 cycles (2+4096+1); each result 256 +/-12; clear cont_mode -> one more pulse, then IDLE.
- rst_n=1 for one cycle mid-RUN -> next cycle busy=0, result=0, result_valid=0; no stale pulse; a fresh start behaves like the first scenario.
- N_CH=4 build, prob={511,0,0,0} -> result 128 +/-12; N_CH=1 build, prob=300 -> result 300 +/-12.
